// File: rtl/inv_cipher_controller.sv
// Iterative AES-128 decryption sequencer: owns the cipher state register and steps it through
// InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, one stage per clock.
module inv_cipher_controller #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned IDX_W      = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [127:0]     data_in,
  output logic [IDX_W-1:0] round_key_idx,
  input  logic [127:0]     round_key,
  input  logic             key_valid,
  output logic [127:0]     state_out,
  input  logic [127:0]     isr_result,
  input  logic [127:0]     isb_result,
  input  logic [127:0]     imc_result,
  output logic             busy,
  output logic             done,
  output logic [127:0]     block_out
);

  localparam logic [IDX_W-1:0] RoundsInit = IDX_W'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StInitArk,
    StIsr,
    StIsb,
    StArk,
    StImc,
    StDone
  } fsm_e;

  fsm_e             fsm_q;
  logic [IDX_W-1:0] round_q;
  logic [127:0]     state_q;
  logic [127:0]     block_q;
  logic             busy_q;
  logic             done_q;
  logic [127:0]     ark_result;

  assign ark_result = state_q ^ round_key;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= StIdle;
      round_q <= RoundsInit;
      state_q <= '0;
      block_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (start) begin
            state_q <= data_in;
            round_q <= RoundsInit;
            busy_q  <= 1'b1;
            fsm_q   <= StInitArk;
          end
        end
        StInitArk: begin
          if (key_valid) begin
            state_q <= ark_result;
            round_q <= round_q - IDX_W'(1);
            fsm_q   <= StIsr;
          end
        end
        StIsr: begin
          state_q <= isr_result;
          fsm_q   <= StIsb;
        end
        StIsb: begin
          state_q <= isb_result;
          fsm_q   <= StArk;
        end
        StArk: begin
          // A missing key freezes everything, including round_key_idx.
          if (key_valid) begin
            state_q <= ark_result;
            if (round_q != '0) begin
              fsm_q <= StImc;
            end else begin
              block_q <= ark_result;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              fsm_q   <= StDone;
            end
          end
        end
        StImc: begin
          state_q <= imc_result;
          round_q <= round_q - IDX_W'(1);
          fsm_q   <= StIsr;
        end
        StDone: begin
          fsm_q <= StIdle;
        end
        default: begin
          fsm_q  <= StIdle;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign round_key_idx = round_q;
  assign state_out     = state_q;
  assign block_out     = block_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_inv_cipher_controller.sv
// Self-checking bench for inv_cipher_controller: models the inverse-transform blocks and key
// expansion, and predicts per-cycle busy/done/idx/state from the AES inverse-cipher round order.
module tb_inv_cipher_controller;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [127:0] data_in;
  logic [3:0]   round_key_idx;
  logic [127:0] round_key;
  logic         key_valid;
  logic [127:0] state_out;
  logic [127:0] isr_result;
  logic [127:0] isb_result;
  logic [127:0] imc_result;
  logic         busy;
  logic         done;
  logic [127:0] block_out;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;

  inv_cipher_controller dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .data_in       (data_in),
    .round_key_idx (round_key_idx),
    .round_key     (round_key),
    .key_valid     (key_valid),
    .state_out     (state_out),
    .isr_result    (isr_result),
    .isb_result    (isb_result),
    .imc_result    (imc_result),
    .busy          (busy),
    .done          (done),
    .block_out     (block_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_prev = 0;
  int done_last = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) begin
    done_prev <= done_last;
    done_last <= cyc;
  end

  logic [7:0]   sbox[256];
  logic [7:0]   isbox[256];
  logic [127:0] rk[11];
  logic [127:0] exp_state[11];
  bit           stub;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b, s, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = xb;
    end
  endtask

  // Byte k of the block is state[row k%4][col k/4]; byte 0 is the MSB.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = isbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] env_isr(input logic [127:0] s);
    return stub ? s + 128'd1 : inv_shift_rows(s);
  endfunction

  function automatic logic [127:0] env_isb(input logic [127:0] s);
    return stub ? s ^ {128{1'b1}} : inv_sub_bytes(s);
  endfunction

  function automatic logic [127:0] env_imc(input logic [127:0] s);
    return stub ? ~s : inv_mix_columns(s);
  endfunction

  assign isr_result = env_isr(state_out);
  assign isb_result = env_isb(state_out);
  assign imc_result = env_imc(state_out);
  assign round_key  = (round_key_idx <= 4'd10) ? rk[round_key_idx] : '0;

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    if (stub) begin
      for (int r = 0; r < 11; r++) rk[r] = '0;
    end else begin
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end
        w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Inverse cipher: ARK(k10), then rounds 9..1 of ISR,ISB,ARK,IMC, then ISR,ISB,ARK(k0).
  // exp_state[j] is the state seen while key j-th in order (index 10-j) is being applied.
  task automatic model(input logic [127:0] data, output logic [127:0] plain);
    logic [127:0] s;
    s = data;
    exp_state[0] = s;
    s = s ^ rk[10];
    for (int j = 1; j <= 10; j++) begin
      s = env_isb(env_isr(s));
      exp_state[j] = s;
      s = s ^ rk[10-j];
      if (j < 10) s = env_imc(s);
    end
    plain = s;
  endtask

  task automatic get_plain(input logic [127:0] key, input logic [127:0] data,
                           output logic [127:0] plain);
    load_keys(key);
    model(data, plain);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called and returns on a falling edge with the DUT idle.
  task automatic run_block(input logic [127:0] key, input logic [127:0] data,
                           input logic [127:0] plain, input int stall_j, input int stall_n,
                           input bit rnd, input int pulse_c, input int abort_c, input bit hold);
    logic [127:0] unused_plain;
    int st[11];
    bit low[128];
    bit dec[128];
    int win[128];
    int t, tf;
    logic [3:0] e_idx;
    load_keys(key);
    model(data, unused_plain);
    for (int c = 0; c < 128; c++) begin
      low[c] = rnd && ($urandom_range(0, 3) == 0);
      dec[c] = 1'b0;
      win[c] = -1;
    end
    for (int j = 0; j < 11; j++) begin
      st[j] = rnd ? int'($urandom_range(0, 2)) : 0;
      if (j == stall_j) st[j] = stall_n;
    end
    t = 1;
    tf = 0;
    for (int j = 0; j < 11; j++) begin
      for (int k = 0; k <= st[j]; k++) begin
        win[t+k] = j;
        low[t+k] = (k < st[j]);
      end
      t = t + st[j];
      if (j == 0) dec[t] = 1'b1;
      if (j >= 1 && j <= 9) dec[t+1] = 1'b1;
      tf = t;
      t = t + ((j == 0) ? 3 : 4);
    end
    data_in = data;
    start = 1'b1;
    key_valid = 1'b1;
    e_idx = 4'd10;
    @(negedge clk);
    for (int c = 1; c <= tf + 2; c++) begin
      if (c == abort_c) begin
        #2 n_rst = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort block_out", block_out, 0);
        chk("abort idx", round_key_idx, 10);
        chk("abort state", state_out, 0);
        @(negedge clk);
        start = 1'b0;
        n_rst = 1'b1;
        return;
      end
      if (!hold) begin
        start = (pulse_c > 0) && (c == pulse_c || c == tf + 1);
        if (start) data_in = rand128();
      end
      key_valid = !low[c];
      chk($sformatf("busy c%0d", c), busy, (c <= tf));
      chk($sformatf("done c%0d", c), done, (c == tf + 1));
      chk($sformatf("idx c%0d", c), round_key_idx, e_idx);
      if (win[c] >= 0) chk($sformatf("state c%0d", c), state_out, exp_state[win[c]]);
      if (c >= tf + 1) chk($sformatf("block_out c%0d", c), block_out, plain);
      if (dec[c]) e_idx = e_idx - 4'd1;
      if (c < tf + 2) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] plain;
    int           stall_j;
    int           stall_n;
    bit           rnd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, d, p;
    n_rst = 1'b1;
    start = 1'b0;
    key_valid = 1'b0;
    data_in = '0;
    stub = 1'b0;
    for (int r = 0; r < 11; r++) rk[r] = '0;
    build_tables();
    #1 n_rst = 1'b0;
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset block_out", block_out, 0);
    chk("reset idx", round_key_idx, 10);
    chk("reset state", state_out, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle idx", round_key_idx, 10);

    tbl[0] = '{FipsKey, FipsCt, FipsPt, -1, 0, 1'b0};
    tbl[1] = '{FipsKey, FipsCt, FipsPt, 5, 3, 1'b0};
    for (int i = 2; i < 6; i++) begin
      k = rand128();
      d = rand128();
      get_plain(k, d, p);
      tbl[i] = '{k, d, p, -1, 0, (i >= 4)};
    end
    for (int i = 0; i < 6; i++)
      run_block(tbl[i].key, tbl[i].data, tbl[i].plain, tbl[i].stall_j, tbl[i].stall_n,
                tbl[i].rnd, 0, 0, 1'b0);

    // start pulses while busy and while in DONE are ignored
    run_block(FipsKey, FipsCt, FipsPt, -1, 0, 1'b0, 10, 0, 1'b0);
    @(negedge clk);
    chk("no accept after DONE", busy, 0);

    // start tied high: blocks accepted back to back
    k = rand128();
    d = rand128();
    get_plain(k, d, p);
    run_block(FipsKey, FipsCt, FipsPt, -1, 0, 1'b0, 0, 0, 1'b1);
    run_block(k, d, p, -1, 0, 1'b0, 0, 0, 1'b1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b done gap", 128'(done_last - done_prev), 42);

    // asynchronous reset mid-operation, then a clean decrypt
    run_block(FipsKey, FipsCt, FipsPt, -1, 0, 1'b0, 0, 20, 1'b0);
    run_block(FipsKey, FipsCt, FipsPt, -1, 0, 1'b1, 0, 0, 1'b0);

    // stub transforms expose the stage order
    stub = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = rand128();
      get_plain('0, d, p);
      run_block('0, d, p, -1, 0, (i == 1), 0, 0, 1'b0);
    end
    stub = 1'b0;

    for (int i = 0; i < 6; i++) begin
      k = rand128();
      d = rand128();
      get_plain(k, d, p);
      run_block(k, d, p, -1, 0, 1'b1, 0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
